// File: rtl/yutorina_bus_if.sv
// yutorina_bus_if: bus master interface between one CPU memory port and one
// master port of the shared yutorina bus. A single-cycle CPU access strobe is
// turned into a full request / grant / strobe / ready transaction, with the
// CPU stalled while the transaction is in flight.
module yutorina_bus_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        as_,
  input  logic [29:0] addr,
  input  logic        rw,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        err,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    STALL
  } state_e;

  // The counter only has to reach TIMEOUT-1, which is at most 254.
  localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT - 1);

  state_e      state;
  state_e      next_state;
  logic [31:0] rd_buf;
  logic [7:0]  counter;

  logic        new_access;
  logic        slave_ready;
  logic        timed_out;
  logic [31:0] access_rd;

  // A new access is only taken from IDLE; a flush in the same cycle cancels it.
  assign new_access  = ~as_ & ~flush;
  assign slave_ready = ~bus_rdy_;
  assign timed_out   = bus_rdy_ && (counter == LAST_CYCLE);
  // Writes return zero so the CPU never sees stale bus data on a store.
  assign access_rd   = bus_rw ? bus_rd_data : 32'd0;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic for the transaction sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (new_access) next_state = REQ;
      end
      REQ: begin
        if (flush)           next_state = IDLE;
        else if (!bus_grnt_) next_state = ACCESS;
      end
      ACCESS: begin
        if (slave_ready || timed_out) next_state = stall ? STALL : IDLE;
      end
      STALL: begin
        if (!stall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // CPU-side outputs, combinational so the result is seen in the completion cycle.
  always_comb begin
    busy    = 1'b0;
    err     = 1'b0;
    rd_data = rd_buf;
    case (state)
      IDLE: begin
        if (new_access) busy = 1'b1;
      end
      REQ: begin
        busy = 1'b1;
      end
      ACCESS: begin
        if (slave_ready) begin
          rd_data = access_rd;
        end else if (timed_out) begin
          err     = 1'b1;
          rd_data = 32'd0;
        end else begin
          busy = 1'b1;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Registered bus signals, read buffer and ACCESS-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= 30'd0;
      bus_wr_data <= 32'd0;
      rd_buf      <= 32'd0;
      counter     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (new_access) begin
            bus_addr    <= addr;
            bus_rw      <= rw;
            bus_wr_data <= wr_data;
            bus_req_    <= 1'b0;
          end
        end
        REQ: begin
          if (flush) begin
            bus_req_ <= 1'b1;
          end else if (!bus_grnt_) begin
            bus_as_ <= 1'b0;
            counter <= 8'd0;
          end
        end
        ACCESS: begin
          bus_as_ <= 1'b1;
          counter <= counter + 8'd1;
          if (slave_ready) begin
            rd_buf   <= access_rd;
            bus_req_ <= 1'b1;
          end else if (timed_out) begin
            rd_buf   <= 32'd0;
            bus_req_ <= 1'b1;
          end
        end
        default: begin
          bus_as_ <= 1'b1;
        end
      endcase
    end
  end

endmodule
